mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Pipeline register between Memory and Writeback in the 5-stage RV32I core.
- Captures Memory-stage results and formats load data (byte/half extraction, sign/zero extension).
- Presents registered Writeback-stage signals to the writeback result mux and register-file write port.
- Also keeps a retired-instruction counter.

Parameters:
- WIDTH, 32, datapath width in bits; only 32 is supported.
- RADDR, 5, register-index width.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stallW  input  1  hold all W registers and the counter.
- flushW  input  1  insert a bubble into W.
- validM  input  1  the M-stage slot holds a real instruction.
- ALUResultM  input  WIDTH  ALU result; also the load address.
- readDataM  input  WIDTH  raw aligned word from data memory.
- PCPlus4M  input  WIDTH  PC+4 of the M instruction.
- rdM  input  RADDR  destination register.
- regWriteM  input  1  instruction writes rd.
- RES_SRC_M  input  2  result select: 00 ALU, 01 load, 10 PC+4.
- funct3M  input  3  load width/sign field.
- ALUResultW  output  WIDTH  registered ALU result.
- readDataW  output  WIDTH  registered, formatted load data.
- PCPlus4W  output  WIDTH  registered PC+4.
- rdW  output  RADDR  registered destination register.
- regWriteW  output  1  register-file write enable.
- RES_SRC_W  output  2  registered result select.
- validW  output  1  the W slot holds a real instruction.
- loadFaultW  output  1  the W instruction was a misaligned or illegal-width load.
- instretW  output  32  count of retired instructions.

Behaviour:
- Latency: 1 cycle from M inputs to W outputs. No combinational path from inputs to outputs.
- Priority per edge: reset > flushW > stallW > capture.
- Reset:
  - All outputs are 0: ALUResultW, readDataW, PCPlus4W, rdW, regWriteW, RES_SRC_W, validW, loadFaultW, instretW.
  - Reset asserted mid-stream discards the in-flight W instruction and clears instretW.
- Flush:
  - validW=0, regWriteW=0, loadFaultW=0, RES_SRC_W=00, rdW=0, all data outputs 0.
  - instretW holds its value.
  - Flush during a stall: the flush wins.
- Stall: every output, including instretW, holds its value.
- Capture (no reset, flush or stall):
  - All M fields are copied to W.
  - validW=validM.
  - regWriteW = regWriteM & validM & ~fault.
- Load formatting applies only when RES_SRC_M=01; otherwise readDataW=readDataM unmodified. With a = ALUResultM[1:0]:
  - 000 lb: sign-extend byte readDataM[8a+7:8a].
  - 100 lbu: zero-extend the same byte.
  - 001 lh: sign-extend halfword readDataM[16a[1]+15:16a[1]]; fault if a[0]=1.
  - 101 lhu: zero-extend the same halfword; same fault rule.
  - 010 lw: whole word; fault if a!=00.
  - Any other funct3: fault.
  - On fault: readDataW=0, loadFaultW=1, regWriteW=0. validW still follows validM.
- fault is only evaluated when RES_SRC_M=01 and validM=1. loadFaultW is 0 otherwise.
- instretW:
  - Increments by 1 on each capture edge where validM=1 and fault=0.
  - Wraps from 0xFFFFFFFF to 0.
- validM=0 with regWriteM=1: regWriteW=0, so no write occurs.

Test Plan:
- Reset for 2 cycles with nonzero inputs → all outputs 0. Release reset with validM=1, RES_SRC_M=00, ALUResultM=0x12345678, rdM=5, regWriteM=1 → next cycle ALUResultW=0x12345678, rdW=5, regWriteW=1, validW=1, instretW=1.
- Loads from readDataM=0x80FF7F01:
  - lb at a=2 → 0xFFFFFFFF.
  - lbu at a=3 → 0x00000080.
  - lh at a=0 → 0x00007F01.
  - lhu at a=2 → 0x000080FF.
  - lw at a=0 → 0x80FF7F01.
  - No loadFaultW in any case.
- Misaligned loads:
  - lw at a=2 → loadFaultW=1, regWriteW=0, readDataW=0, instretW unchanged.
  - lh at a=1 → same.
  - funct3=011 load → same.
- Stall for 3 cycles while inputs change → W outputs and instretW frozen. Assert flushW together with stallW → bubble next cycle (validW=0, regWriteW=0).
- Preload instretW to 0xFFFFFFFE via 0xFFFFFFFE valid captures, or a forced state in simulation, then 2 valid captures → 0xFFFFFFFF then 0x00000000.
- RES_SRC_M=10, PCPlus4M=0x00000104, regWriteM=1, validM=0 → PCPlus4W=0x00000104, RES_SRC_W=10, regWriteW=0, validW=0, instretW unchanged.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory/Writeback pipeline register for the RV32I core: captures M-stage results,
// formats load data (byte/half extraction, sign/zero extension) and counts retired instructions.
module mem_wb_stage #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallW,
    input  logic             flushW,
    input  logic             validM,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] readDataM,
    input  logic [WIDTH-1:0] PCPlus4M,
    input  logic [RADDR-1:0] rdM,
    input  logic             regWriteM,
    input  logic [1:0]       RES_SRC_M,
    input  logic [2:0]       funct3M,
    output logic [WIDTH-1:0] ALUResultW,
    output logic [WIDTH-1:0] readDataW,
    output logic [WIDTH-1:0] PCPlus4W,
    output logic [RADDR-1:0] rdW,
    output logic             regWriteW,
    output logic [1:0]       RES_SRC_W,
    output logic             validW,
    output logic             loadFaultW,
    output logic [31:0]      instretW
);

    localparam int LANES = WIDTH / 8;

    logic [7:0]       lane [LANES];
    logic [1:0]       addr_lo;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic             misalign;
    logic             is_load;
    logic             fault_next;
    logic             retire;
    logic [WIDTH-1:0] load_data_next;
    logic [31:0]      instret_next;

    logic [WIDTH-1:0] alu_result_reg;
    logic [WIDTH-1:0] read_data_reg;
    logic [WIDTH-1:0] pc_plus4_reg;
    logic [RADDR-1:0] rd_reg;
    logic             reg_write_reg;
    logic [1:0]       res_src_reg;
    logic             valid_reg;
    logic             load_fault_reg;
    logic [31:0]      instret_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane[gi] = readDataM[8*gi +: 8];
        end
    endgenerate

    assign addr_lo  = ALUResultM[1:0];
    assign byte_sel = lane[addr_lo];
    assign half_sel = addr_lo[1] ? readDataM[31:16] : readDataM[15:0];
    assign is_load  = (RES_SRC_M == 2'b01);

    always_comb begin
        load_data_next = readDataM;
        misalign       = 1'b0;
        if (is_load) begin
            case (funct3M)
                3'b000: load_data_next = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
                3'b100: load_data_next = {{(WIDTH-8){1'b0}}, byte_sel};
                3'b001: begin
                    load_data_next = {{(WIDTH-16){half_sel[15]}}, half_sel};
                    misalign       = addr_lo[0];
                end
                3'b101: begin
                    load_data_next = {{(WIDTH-16){1'b0}}, half_sel};
                    misalign       = addr_lo[0];
                end
                3'b010: misalign = (addr_lo != 2'b00);
                default: misalign = 1'b1;
            endcase
        end
        // Faults only matter for real load instructions; a faulting load returns zero.
        fault_next = is_load & validM & misalign;
        if (fault_next) begin
            load_data_next = '0;
        end
        retire       = validM & ~fault_next;
        instret_next = instret_reg + {31'b0, retire};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result_reg <= '0;
            read_data_reg  <= '0;
            pc_plus4_reg   <= '0;
            rd_reg         <= '0;
            reg_write_reg  <= 1'b0;
            res_src_reg    <= 2'b00;
            valid_reg      <= 1'b0;
            load_fault_reg <= 1'b0;
            instret_reg    <= '0;
        end else if (flushW) begin
            // Bubble: the retire count is left untouched.
            alu_result_reg <= '0;
            read_data_reg  <= '0;
            pc_plus4_reg   <= '0;
            rd_reg         <= '0;
            reg_write_reg  <= 1'b0;
            res_src_reg    <= 2'b00;
            valid_reg      <= 1'b0;
            load_fault_reg <= 1'b0;
        end else if (!stallW) begin
            alu_result_reg <= ALUResultM;
            read_data_reg  <= load_data_next;
            pc_plus4_reg   <= PCPlus4M;
            rd_reg         <= rdM;
            reg_write_reg  <= regWriteM & validM & ~fault_next;
            res_src_reg    <= RES_SRC_M;
            valid_reg      <= validM;
            load_fault_reg <= fault_next;
            instret_reg    <= instret_next;
        end
    end

    assign ALUResultW = alu_result_reg;
    assign readDataW  = read_data_reg;
    assign PCPlus4W   = pc_plus4_reg;
    assign rdW        = rd_reg;
    assign regWriteW  = reg_write_reg;
    assign RES_SRC_W  = res_src_reg;
    assign validW     = valid_reg;
    assign loadFaultW = load_fault_reg;
    assign instretW   = instret_reg;

endmodule
